sm_program_loader: RTL
======================

Name: sm_program_loader

Overview:
- Writer end of the stack machine's instruction memory.
- Receives a framed byte stream over a valid/ready handshake and checks each instruction.
- Writes each instruction as one 12-bit word: 4-bit opcode in bits [11:8], 8-bit value in bits [7:0].
- Holds the stack machine in reset while loading. Releases it only after the frame checksum verifies.

Parameters:
- ADDR_W, 5, instruction memory address width.
- DEPTH, 32, maximum instructions per frame (must be at most 2^ADDR_W).
- NUM_OPS, 8, valid opcodes are 0 to NUM_OPS-1.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready at a clk edge.
- imem_we  out  1  instruction memory write strobe, one cycle wide.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  12  {op[3:0], value[7:0]}.
- cpu_rstN  out  1  active-low reset to the stack machine.
- busy  out  1  a frame is in progress (any state other than HUNT and RELEASE).
- done  out  1  one-cycle pulse when a frame is accepted.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 bad length, 2 bad opcode, 3 checksum mismatch.

Behaviour:
- Frame format: SYNC, LEN, then LEN pairs of {8'h0 op-byte, value-byte}, then CSUM.
  - The 8-bit sum of LEN, every payload byte and CSUM must equal 0 (mod 256).
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rstN 0, busy 0, done 0, err 0, err_code 0. State is HUNT.
- in_ready is 1 in every state except RELEASE and except the reset cycle.
- HUNT:
  - Accepted bytes other than SYNC are discarded.
  - On SYNC: go to LEN, drive cpu_rstN 0, clear err/err_code, clear checksum accumulator, set word counter to 0.
- LEN:
  - If LEN == 0 or LEN > DEPTH: err=1, err_code=1, go to HUNT.
  - Otherwise latch LEN, add it to the accumulator, go to OP.
- OP:
  - If byte[7:4] != 0 or byte[3:0] >= NUM_OPS: err=1, err_code=2, go to HUNT. No write occurs for that word.
  - Otherwise latch op, accumulate, go to VAL.
- VAL:
  - Accumulate.
  - On the next cycle: imem_we=1, imem_addr=counter, imem_wdata={op,byte}.
  - Increment counter. If counter+1 == LEN go to CSUM, else go to OP.
- CSUM:
  - If accumulator + byte == 0: go to RELEASE.
  - Otherwise: err=1, err_code=3, go to HUNT, cpu_rstN stays 0.
- RELEASE (one cycle): cpu_rstN <= 1, done pulses 1, in_ready 0, then go to HUNT.
- cpu_rstN stays 1 until the next SYNC is accepted.
- imem_we latency: exactly one cycle after the VAL handshake; never asserted in any other case.
- Failed frame: words already written stay in memory. cpu_rstN low guarantees they never execute.
- Stall: in_valid low in any state holds state, accumulator and counter. No timeout.
- Error in HUNT: err stays set until the next SYNC is accepted.
- SYNC value inside a frame is treated as ordinary data, not as a restart.
- rst mid-frame: all outputs return to reset values on the next edge; any pending imem write is cancelled.
- Arithmetic: accumulator is 8-bit, wraps modulo 256. Counter is ADDR_W+1 bits so that LEN == DEPTH is reachable.

Decomposition:
- Package sm_pkg holds:
  - opcode localparams (pushc 0, pushmem 1, pop 2, j 3, jz 4, js 5, add 6, sub 7);
  - SYNC;
  - err_code constants;
  - the state encoding: HUNT, LEN, OP, VAL, CSUM, RELEASE.
- One sub-module, sm_checksum: 8-bit wrapping accumulator with clear, add-enable, and a combinational zero-check on acc + next byte.

Test Plan:
1. Stream A5 01 00 05 FA with in_valid high. Expect:
   - one write: addr 0, wdata 12'h005;
   - done pulse;
   - cpu_rstN 1 in the cycle after RELEASE;
   - err 0.
2. Stream A5 02 00 03 06 00 F5 with in_valid toggling every other cycle. Expect:
   - writes addr0=12'h003 and addr1=12'h600;
   - each write exactly one cycle after its value byte handshake;
   - done pulse.
3. Stream A5 00, then A5 21. Expect:
   - err_code 1 each time;
   - no imem_we;
   - cpu_rstN stays 0;
   - a following valid frame clears err and loads.
4. Stream A5 02 00 03 09 …. Expect:
   - err_code 2 on byte 09;
   - only addr0 written;
   - state back to HUNT (later bytes ignored until the next A5).
5. Stream A5 01 00 05 FB. Expect:
   - addr0 written;
   - err_code 3;
   - no done;
   - cpu_rstN remains 0.
6. Assert rst between the OP and VAL bytes of a valid frame. Expect:
   - all outputs at reset values;
   - no write;
   - a fresh full frame then loads correctly.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared constants for the stack machine program loader: opcodes, frame sync byte,
// error codes and loader state encoding.
package sm_pkg;

    localparam int unsigned IMEM_W = 12;

    localparam logic [7:0] SM_SYNC = 8'hA5;

    localparam logic [3:0] OP_PUSHC   = 4'd0;
    localparam logic [3:0] OP_PUSHMEM = 4'd1;
    localparam logic [3:0] OP_POP     = 4'd2;
    localparam logic [3:0] OP_J       = 4'd3;
    localparam logic [3:0] OP_JZ      = 4'd4;
    localparam logic [3:0] OP_JS      = 4'd5;
    localparam logic [3:0] OP_ADD     = 4'd6;
    localparam logic [3:0] OP_SUB     = 4'd7;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_OP   = 2'd2;
    localparam logic [1:0] ERR_CSUM = 2'd3;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        OP,
        VAL,
        CSUM,
        RELEASE
    } state_e;

endpackage

// File: rtl/sm_checksum.sv
// 8-bit wrapping frame checksum accumulator with a combinational
// "accumulator plus incoming byte is zero" check.
module sm_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic [7:0] i_data,
    output logic       o_zero_c
);

    logic [7:0] r_acc;
    logic [7:0] w_sum;

    assign w_sum    = 8'(r_acc + i_data);
    assign o_zero_c = (w_sum == 8'h00);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= 8'h00;
        end else if (i_add) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/sm_program_loader.sv
// Framed byte-stream loader for the stack machine instruction memory; holds the
// machine in reset until a complete frame with a good checksum has been written.
module sm_program_loader
    import sm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned NUM_OPS = 8,
    parameter logic [7:0]  SYNC    = SM_SYNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [IMEM_W-1:0] imem_wdata,
    output logic              cpu_rstN,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam logic [7:0]  DEPTH_B   = 8'(DEPTH);
    localparam logic [4:0]  NUM_OPS_B = 5'(NUM_OPS);

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d, w_cnt_inc;
    logic [CNT_W-1:0]    r_len, w_len_d;
    logic [3:0]          r_op, w_op_d;

    logic                r_in_ready, w_in_ready_d;
    logic                r_we, w_we_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [IMEM_W-1:0]   r_wdata, w_wdata_d;
    logic                r_cpu_rstn, w_cpu_rstn_d;
    logic                r_busy, w_busy_d;
    logic                r_done, w_done_d;
    logic                r_err, w_err_d;
    logic [1:0]          r_err_code, w_err_code_d;

    logic                w_xfer;
    logic                w_acc_clr;
    logic                w_acc_add;
    logic                w_csum_ok;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    sm_checksum u_checksum (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_acc_clr),
        .i_add    (w_acc_add),
        .i_data   (in_data),
        .o_zero_c (w_csum_ok)
    );

    // Next-state and next-output logic; nothing moves unless a byte transfers.
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_len_d      = r_len;
        w_op_d       = r_op;
        w_we_d       = 1'b0;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_cpu_rstn_d = r_cpu_rstn;
        w_err_d      = r_err;
        w_err_code_d = r_err_code;
        w_acc_clr    = 1'b0;
        w_acc_add    = 1'b0;

        case (r_state)
            HUNT: begin
                if (w_xfer && (in_data == SYNC)) begin
                    w_state_d    = LEN;
                    w_cpu_rstn_d = 1'b0;
                    w_err_d      = 1'b0;
                    w_err_code_d = ERR_NONE;
                    w_acc_clr    = 1'b1;
                    w_cnt_d      = '0;
                end
            end
            LEN: begin
                if (w_xfer) begin
                    if ((in_data == 8'h00) || (in_data > DEPTH_B)) begin
                        w_state_d    = HUNT;
                        w_err_d      = 1'b1;
                        w_err_code_d = ERR_LEN;
                    end else begin
                        w_len_d   = CNT_W'(in_data);
                        w_acc_add = 1'b1;
                        w_state_d = OP;
                    end
                end
            end
            OP: begin
                if (w_xfer) begin
                    if ((in_data[7:4] != 4'h0) || ({1'b0, in_data[3:0]} >= NUM_OPS_B)) begin
                        w_state_d    = HUNT;
                        w_err_d      = 1'b1;
                        w_err_code_d = ERR_OP;
                    end else begin
                        w_op_d    = in_data[3:0];
                        w_acc_add = 1'b1;
                        w_state_d = VAL;
                    end
                end
            end
            VAL: begin
                if (w_xfer) begin
                    w_acc_add = 1'b1;
                    w_we_d    = 1'b1;
                    w_addr_d  = r_cnt[ADDR_W-1:0];
                    w_wdata_d = {r_op, in_data};
                    w_cnt_d   = w_cnt_inc;
                    w_state_d = (w_cnt_inc == r_len) ? CSUM : OP;
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    if (w_csum_ok) begin
                        w_state_d = RELEASE;
                    end else begin
                        w_state_d    = HUNT;
                        w_err_d      = 1'b1;
                        w_err_code_d = ERR_CSUM;
                    end
                end
            end
            RELEASE: begin
                w_state_d    = HUNT;
                w_cpu_rstn_d = 1'b1;
            end
            default: begin
                w_state_d = HUNT;
            end
        endcase

        w_in_ready_d = (w_state_d != RELEASE);
        w_done_d     = (w_state_d == RELEASE);
        w_busy_d     = (w_state_d == LEN) || (w_state_d == OP) ||
                       (w_state_d == VAL) || (w_state_d == CSUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_cnt      <= '0;
            r_len      <= '0;
            r_op       <= 4'h0;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cpu_rstn <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_len      <= w_len_d;
            r_op       <= w_op_d;
            r_in_ready <= w_in_ready_d;
            r_we       <= w_we_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_cpu_rstn <= w_cpu_rstn_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
            r_err_code <= w_err_code_d;
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rstN   = r_cpu_rstn;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
